// File: rtl/platform_collision.sv
// Per-frame landing detector: snapshots platforms and doodle, scans one platform per cycle.
// Optional PLATFORM_COLLISION_STATS_EN adds land_count and overrun outputs.
module platform_collision (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [1:0] frame_clk_edge,
  input  logic [9:0] Platform_X_in [0:7],
  input  logic [9:0] Platform_Y_in [0:7],
  input  logic [7:0] platform_size,
  input  logic [9:0] Doodle_X,
  input  logic [9:0] Doodle_Y,
  input  logic [7:0] Doodle_Size,
  input  logic [9:0] Doodle_Y_motion,
  output logic       busy,
  output logic       land,
  output logic [2:0] land_idx,
  output logic [9:0] land_Y,
  output logic [7:0] hit_mask
`ifdef PLATFORM_COLLISION_STATS_EN
  ,
  output logic [15:0] land_count,
  output logic        overrun
`endif
);

  localparam int          N_PLAT = 8;
  localparam logic [10:0] Y_MAX  = 11'd239;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_t;

  state_t state, state_n;

  logic [9:0] s_px [0:N_PLAT-1];
  logic [9:0] s_py [0:N_PLAT-1];
  logic [7:0] s_psize;
  logic [9:0] s_dx;
  logic [9:0] s_dy;
  logic [7:0] s_dsize;
  logic [9:0] s_dmot;

  logic [2:0] idx;
  logic       cand_vld;
  logic [2:0] cand_idx;
  logic [9:0] cand_y;
  logic [7:0] wmask;

  logic        start;
  logic        falling;
  logic        vert;
  logic        horiz;
  logic        hit;
  logic        take;
  logic [10:0] feet;
  logic [10:0] fall_to;
  logic [10:0] p_x;
  logic [10:0] p_y;
  logic [10:0] d_right;
  logic [10:0] p_right;
  logic [7:0]  mask_n;
  logic        cvld_n;
  logic [2:0]  cidx_n;
  logic [9:0]  cy_n;

  assign start = (frame_clk_edge == 2'b01);

  // Hit test on the snapshot, widened to 11 bits so nothing wraps
  always_comb begin
    p_x     = {1'b0, s_px[idx]};
    p_y     = {1'b0, s_py[idx]};
    feet    = {1'b0, s_dy} + {3'b0, s_dsize};
    fall_to = feet + {1'b0, s_dmot};
    d_right = {1'b0, s_dx} + {3'b0, s_dsize};
    p_right = p_x + {3'b0, s_psize};
    falling = !s_dmot[9] && (s_dmot != 10'd0);
    vert    = (feet <= p_y) && (fall_to >= p_y);
    horiz   = (d_right > p_x) && ({1'b0, s_dx} < p_right);
    hit     = falling && vert && horiz && (p_y <= Y_MAX);
    take    = hit && (!cand_vld || (s_py[idx] < cand_y));
  end

  always_comb begin
    mask_n = wmask;
    cvld_n = cand_vld;
    cidx_n = cand_idx;
    cy_n   = cand_y;
    if (hit) mask_n[idx] = 1'b1;
    if (take) begin
      cvld_n = 1'b1;
      cidx_n = idx;
      cy_n   = s_py[idx];
    end
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    land    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (idx == 3'd7) state_n = REPORT;
      end
      REPORT: begin
        busy    = 1'b1;
        land    = cand_vld;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      idx      <= '0;
      cand_vld <= 1'b0;
      cand_idx <= '0;
      cand_y   <= '0;
      wmask    <= '0;
      land_idx <= '0;
      land_Y   <= '0;
      hit_mask <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx      <= '0;
            cand_vld <= 1'b0;
            wmask    <= '0;
          end
        end
        SCAN: begin
          idx      <= idx + 3'd1;
          cand_vld <= cvld_n;
          cand_idx <= cidx_n;
          cand_y   <= cy_n;
          wmask    <= mask_n;
          // Results become visible together with the land pulse
          if (idx == 3'd7) begin
            hit_mask <= mask_n;
            if (cvld_n) begin
              land_idx <= cidx_n;
              land_Y   <= cy_n;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < N_PLAT; i++) begin
        s_px[i] <= Platform_X_in[i];
        s_py[i] <= Platform_Y_in[i];
      end
      s_psize <= platform_size;
      s_dx    <= Doodle_X;
      s_dy    <= Doodle_Y;
      s_dsize <= Doodle_Size;
      s_dmot  <= Doodle_Y_motion;
    end
  end

`ifdef PLATFORM_COLLISION_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      land_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (land && land_count != 16'hFFFF) land_count <= land_count + 16'd1;
      if (busy && start) overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_platform_collision.sv
// Scoreboard bench for platform_collision: a reference model predicts each frame's report.
// Expected results are queued at the frame edge and checked on the report cycle.
module tb_platform_collision;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [1:0] frame_clk_edge = 2'b00;
  logic [9:0] Platform_X_in [0:7];
  logic [9:0] Platform_Y_in [0:7];
  logic [7:0] platform_size = 8'd60;
  logic [9:0] Doodle_X = '0;
  logic [9:0] Doodle_Y = '0;
  logic [7:0] Doodle_Size = '0;
  logic [9:0] Doodle_Y_motion = '0;
  logic       busy;
  logic       land;
  logic [2:0] land_idx;
  logic [9:0] land_Y;
  logic [7:0] hit_mask;
`ifdef PLATFORM_COLLISION_STATS_EN
  logic [15:0] land_count;
  logic        overrun;
  int          exp_count = 0;
  bit          exp_overrun = 0;
`endif

  platform_collision dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_clk_edge(frame_clk_edge),
    .Platform_X_in(Platform_X_in),
    .Platform_Y_in(Platform_Y_in),
    .platform_size(platform_size),
    .Doodle_X(Doodle_X),
    .Doodle_Y(Doodle_Y),
    .Doodle_Size(Doodle_Size),
    .Doodle_Y_motion(Doodle_Y_motion),
    .busy(busy),
    .land(land),
    .land_idx(land_idx),
    .land_Y(land_Y),
    .hit_mask(hit_mask)
`ifdef PLATFORM_COLLISION_STATS_EN
    ,
    .land_count(land_count),
    .overrun(overrun)
`endif
  );

  always #10 Clk = ~Clk;

  typedef struct {
    bit       land;
    bit [2:0] idx;
    bit [9:0] y;
    bit [7:0] mask;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit [2:0] last_idx = 0;
  bit [9:0] last_y = 0;

  function automatic exp_t model();
    exp_t e;
    int feet, px, py, dx, ds, mot;
    bit fall;
    e.land = 0;
    e.idx  = last_idx;
    e.y    = last_y;
    e.mask = 0;
    ds   = Doodle_Size;
    dx   = Doodle_X;
    feet = Doodle_Y + ds;
    fall = !Doodle_Y_motion[9] && Doodle_Y_motion != 0;
    mot  = Doodle_Y_motion;
    for (int i = 0; i < 8; i++) begin
      px = Platform_X_in[i];
      py = Platform_Y_in[i];
      if (fall && py <= 239 && feet <= py && feet + mot >= py &&
          dx + ds > px && dx < px + platform_size) begin
        e.mask[i] = 1'b1;
        if (!e.land || py < e.y) begin
          e.land = 1;
          e.idx  = i[2:0];
          e.y    = py[9:0];
        end
      end
    end
    return e;
  endfunction

  task automatic clear_plats();
    for (int i = 0; i < 8; i++) begin
      Platform_X_in[i] = 10'd0;
      Platform_Y_in[i] = 10'd300;
    end
    platform_size = 8'd60;
  endtask

  task automatic set_doodle(input int x, input int y, input int s, input logic [9:0] m);
    Doodle_X        = x[9:0];
    Doodle_Y        = y[9:0];
    Doodle_Size     = s[7:0];
    Doodle_Y_motion = m;
  endtask

  // Drives one frame edge and monitors 14 cycles after it
  task automatic run_frame(input string name, input bit busy_edge, input bit perturb);
    exp_t e;
    @(negedge Clk);
    q.push_back(model());
    frame_clk_edge = 2'b01;
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clk);
      checks++;
      if (busy !== (k <= 9)) begin
        errors++;
        $display("FAIL %s busy k=%0d got %b want %b", name, k, busy, (k <= 9));
      end
      if (k == 9) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL %s scoreboard empty", name);
        end else begin
          e = q.pop_front();
          checks++;
          if (land !== e.land || hit_mask !== e.mask ||
              land_idx !== e.idx || land_Y !== e.y) begin
            errors++;
            $display("FAIL %s report got land=%b idx=%0d y=%0d mask=%h want land=%b idx=%0d y=%0d mask=%h",
                     name, land, land_idx, land_Y, hit_mask, e.land, e.idx, e.y, e.mask);
          end
          last_idx = e.idx;
          last_y   = e.y;
`ifdef PLATFORM_COLLISION_STATS_EN
          if (e.land) exp_count++;
          if (busy_edge) exp_overrun = 1;
`endif
        end
      end else begin
        checks++;
        if (land !== 1'b0) begin
          errors++;
          $display("FAIL %s stray land k=%0d got %b want 0", name, k, land);
        end
      end
`ifdef PLATFORM_COLLISION_STATS_EN
      if (k == 11) begin
        checks++;
        if (land_count !== exp_count[15:0] || overrun !== exp_overrun) begin
          errors++;
          $display("FAIL %s stats got cnt=%0d ovr=%b want cnt=%0d ovr=%b",
                   name, land_count, overrun, exp_count, exp_overrun);
        end
      end
`endif
      frame_clk_edge = (busy_edge && k == 4) ? 2'b01 :
                       (k == 6) ? 2'b10 : 2'b00;
      if (perturb && k == 2) set_doodle(500, 0, 200, 10'd100);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (busy !== 0 || land !== 0 || land_idx !== 0 || land_Y !== 0 || hit_mask !== 0) begin
      errors++;
      $display("FAIL %s got busy=%b land=%b idx=%0d y=%0d mask=%h want all 0",
               name, busy, land, land_idx, land_Y, hit_mask);
    end
  endtask

  task automatic test_reset();
    Reset_n = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1;
    @(negedge Clk);
    check_zero("reset");
    last_idx = 0;
    last_y   = 0;
  endtask

  task automatic test_single_hit();
    clear_plats();
    Platform_X_in[3] = 10'd130;
    Platform_Y_in[3] = 10'd100;
    set_doodle(140, 80, 16, 10'd5);
    run_frame("single_hit", 0, 0);
  endtask

  task automatic test_rising();
    set_doodle(140, 80, 16, 10'h3FB);
    run_frame("rising", 0, 0);
  endtask

  task automatic test_two_cand();
    clear_plats();
    Platform_X_in[2] = 10'd130;
    Platform_Y_in[2] = 10'd100;
    Platform_X_in[5] = 10'd120;
    Platform_Y_in[5] = 10'd98;
    set_doodle(140, 80, 16, 10'd6);
    run_frame("two_cand_smaller_y", 0, 0);
    Platform_Y_in[5] = 10'd100;
    run_frame("two_cand_tie", 0, 0);
  endtask

  task automatic test_horiz_edge();
    clear_plats();
    Platform_X_in[3] = 10'd130;
    Platform_Y_in[3] = 10'd100;
    set_doodle(114, 80, 16, 10'd5);
    run_frame("horiz_miss", 0, 0);
    set_doodle(115, 80, 16, 10'd5);
    run_frame("horiz_hit", 0, 0);
    Platform_Y_in[3] = 10'd240;
    set_doodle(140, 220, 16, 10'd5);
    run_frame("below_ymax", 0, 0);
  endtask

  task automatic test_edge_busy();
    clear_plats();
    Platform_X_in[6] = 10'd100;
    Platform_Y_in[6] = 10'd150;
    set_doodle(120, 130, 16, 10'd8);
    run_frame("edge_busy", 1, 0);
  endtask

  task automatic test_snapshot();
    clear_plats();
    Platform_X_in[1] = 10'd200;
    Platform_Y_in[1] = 10'd60;
    set_doodle(210, 40, 16, 10'd4);
    run_frame("snapshot", 0, 1);
  endtask

  task automatic test_reset_mid_scan();
    @(negedge Clk);
    frame_clk_edge = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      @(negedge Clk);
      frame_clk_edge = 2'b00;
      if (k == 3) Reset_n = 0;
      if (k == 5) Reset_n = 1;
      if (k == 6) check_zero("mid_reset");
      if (k > 6) begin
        checks++;
        if (land !== 0 || busy !== 0) begin
          errors++;
          $display("FAIL mid_reset_after k=%0d got land=%b busy=%b want 0 0", k, land, busy);
        end
      end
    end
    last_idx = 0;
    last_y   = 0;
`ifdef PLATFORM_COLLISION_STATS_EN
    exp_count   = 0;
    exp_overrun = 0;
`endif
  endtask

  initial begin
    clear_plats();
    test_reset();
    test_single_hit();
    test_rising();
    test_two_cand();
    test_horiz_edge();
    test_edge_busy();
    test_snapshot();
    test_single_hit();
    test_reset_mid_scan();
    test_single_hit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/platform_collision.md
Name: platform_collision

Overview:
- Consumer of the platform position arrays driven by the platform mover. Reads positions once per frame.
- Once per frame, snapshots all 8 platform positions and the doodle's position and vertical velocity.
- Scans the 8 platforms sequentially, one per cycle, and reports whether the falling doodle lands on one.
- Reports which platform and its top Y, so the doodle physics block can bounce.

Parameters:
- N_PLAT, 8: number of platforms scanned; index width is 3.
- Y_MAX, 239: bottom screen row; platforms with Y > Y_MAX are ignored.

Ports:
- Clk  input  1  50 MHz system clock
- Reset_n  input  1  synchronous active-low reset
- frame_clk_edge  input  2  frame edge code; 2'b01 = start of frame
- Platform_X_in  input  10 x [0:7]  platform left X, unsigned
- Platform_Y_in  input  10 x [0:7]  platform top Y, unsigned
- platform_size  input  8  platform width in pixels
- Doodle_X  input  10  doodle left X
- Doodle_Y  input  10  doodle top Y
- Doodle_Size  input  8  doodle width and height
- Doodle_Y_motion  input  10  signed two's-complement vertical step; positive = falling
- busy  output  1  high while snapshot/scan/report in progress
- land  output  1  one-cycle pulse: landing detected this frame
- land_idx  output  3  index of the landed platform; valid with land, held until the next land pulse
- land_Y  output  10  Platform_Y of the landed platform; valid with land, held until the next land pulse
- hit_mask  output  8  per-platform hit bits from the last completed scan

Behaviour:
- Reset (Reset_n=0 sampled at a posedge):
  - State = IDLE.
  - busy=0, land=0, land_idx=0, land_Y=0, hit_mask=0.
  - Reset mid-scan aborts the scan; no land pulse is issued.
- FSM states: IDLE, SCAN, REPORT.
- IDLE:
  - If frame_clk_edge==2'b01 at posedge N:
    - Register all inputs into the snapshot.
    - Clear the scan index, candidate-valid flag and working mask.
    - Go to SCAN; busy=1 from N+1.
- SCAN:
  - At cycles N+1..N+8, evaluate platform i = 0..7, one per cycle.
  - After i=7, go to REPORT.
- REPORT, cycle N+9:
  - hit_mask <= working mask.
  - If a candidate exists: land=1 for exactly this cycle, and land_idx / land_Y are updated.
  - Go to IDLE; busy=0 from N+10.
  - The total frame-edge-to-land latency is 9 cycles.
- Hit test for platform i, all arithmetic 11-bit unsigned (no wrap):
  - falling = Doodle_Y_motion[9]==0 and Doodle_Y_motion != 0.
  - feet = Doodle_Y + Doodle_Size.
  - Vertical condition: feet <= Py and feet + Doodle_Y_motion >= Py.
  - Horizontal condition: Doodle_X + Doodle_Size > Px and Doodle_X < Px + platform_size.
  - Py > Y_MAX: never a hit.
  - hit = falling and vertical and horizontal.
- Arbitration:
  - Among hits, the candidate with the smallest Py wins (first surface crossed).
  - Equal Py: the lower index wins, i.e. replace only on strictly smaller Py.
- Edge arrival:
  - frame_clk_edge==2'b01 while busy is ignored; no queueing.
  - Other edge codes are always ignored.
- No hits: land stays 0; land_idx and land_Y hold their previous values; hit_mask=0.
- Input changes after the snapshot have no effect on the current scan.

Optional Feature:
- Macro: PLATFORM_COLLISION_STATS_EN.
- Defined:
  - Adds output land_count (16-bit), reset 0.
  - Increments on every land pulse and saturates at 16'hFFFF.
  - Adds output overrun (1-bit sticky), set when a 2'b01 edge arrives while busy; cleared only by reset.
- Undefined: neither port nor its logic exists; behaviour is otherwise identical.

Test Plan:
- Reset_n=0 for 2 cycles mid-SCAN -> next cycle busy=0, land=0, hit_mask=0; no land pulse follows.
- Single hit:
  - Stimulus: platform 3 at (130,100), size 60; doodle X=140, Y=80, Size=16, motion=+5 (feet 96 -> 101); edge at N.
  - Required: land=1 only at N+9, land_idx=3, land_Y=100, hit_mask=8'h08, busy high N+1..N+9.
- Rising doodle:
  - Stimulus: same geometry as the single-hit case, motion=-5 (10'h3FB).
  - Required: no land pulse; hit_mask=0; land_idx and land_Y unchanged.
- Two candidates:
  - Stimulus: platform 2 Y=100 and platform 5 Y=98, both overlapping in X; feet 96, motion +6.
  - Required: land_idx=5, land_Y=98, hit_mask=8'h24.
  - Repeat with both Y=100: land_idx=2.
- Horizontal edge:
  - Doodle X=114, Size 16, platform X=130: no hit, since X-overlap requires Doodle_X + Doodle_Size > Px (130 > 130 false).
  - Doodle X=115: hit.
- Edge while busy:
  - Stimulus: second 2'b01 at N+4.
  - Required: ignored; only one land pulse, at N+9.
  - With PLATFORM_COLLISION_STATS_EN defined: overrun=1, land_count=1.
